msrr8_rot_ctrl: RTL

Sequencing controller for the 8-bit multi-mode shift/rotate register (`MSRR8_Q10`). On a start request it loads a byte serially through the register's shift-in mode, then rotates the contents right by a requested amount, and finally flags completion. It drives the register's `mode` and `sIn` inputs directly and shares the register's clock.

---
 rtl/msrr8_rot_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/msrr8_rot_ctrl.sv
// msrr8_rot_ctrl
// Sequencing controller for the 8-bit multi-mode shift/rotate register.
// Accepts a byte and a rotate amount, shifts the byte into the register
// LSB first (mode 11), rotates it right by the amount, then pulses done.
//
// Optional feature macro: MSRR8_ROT_FAST_EN
//   defined   -> ROT uses mode 10 (rotate by 2) while at least 2 steps
//                remain, finishing with one mode 01 if the amount is odd.
//   undefined -> ROT uses only mode 01, one step per cycle.
//
// Handshake: start is a level request sampled only in IDLE; the rising
// edge that sees start=1 in IDLE accepts the operation and latches
// data_in/rot_amt. There is no ready output; busy/done report progress.
// All outputs are decoded from registered state only, so the async reset
// forces the idle output values immediately.
module msrr8_rot_ctrl (
    input  logic       clc,
    input  logic       R,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic [2:0] rot_amt,
    output logic [1:0] mode,
    output logic       ser_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ROT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ROR1 = 2'b01;
    localparam logic [1:0] MODE_ROR2 = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [7:0] data_q;
    logic [2:0] rem_q;
    logic [2:0] rot_step;
    logic       rot_last;

    // Rotate step size for the current ROT cycle and whether it finishes.
    always_comb begin
`ifdef MSRR8_ROT_FAST_EN
        rot_step = (rem_q >= 3'd2) ? 3'd2 : 3'd1;
`else
        rot_step = 3'd1;
`endif
        rot_last = (rem_q == rot_step);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clc or negedge R) begin
        if (!R) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (cnt == 3'd7) begin
                    state_nxt = (rem_q != 3'd0) ? S_ROT : S_DONE;
                end
            end
            S_ROT:  if (rot_last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latches and step counter; the counter wraps 7->0 leaving LOAD.
    always_ff @(posedge clc or negedge R) begin
        if (!R) begin
            cnt    <= 3'd0;
            data_q <= 8'd0;
            rem_q  <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        data_q <= data_in;
                        rem_q  <= rot_amt;
                        cnt    <= 3'd0;
                    end
                end
                S_LOAD:  cnt   <= cnt + 3'd1;
                S_ROT:   rem_q <= rem_q - rot_step;
                default: ;
            endcase
        end
    end

    // Output decode from registered state, counter and latches only.
    always_comb begin
        mode      = MODE_HOLD;
        ser_out   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = state;
        case (state)
            S_LOAD: begin
                mode    = MODE_SHR;
                ser_out = data_q[cnt];
                busy    = 1'b1;
            end
            S_ROT: begin
                mode = (rot_step == 3'd2) ? MODE_ROR2 : MODE_ROR1;
                busy = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
